noc_merge_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/noc_merge_arbiter.sv | 97 +++++++++
 tb/tb_noc_merge_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the 9-bit flit datapath.
// Flit layout: bits [8:5] carry the destination address, bits [4:0] the payload.
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 5;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [3:0]        noc_addr_t;

    // Extracts the address field of a flit.
    function automatic noc_addr_t flit_addr(input flit_t f);
        return f[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational rotate-priority picker.
// Searches req starting at index ptr, ascending and wrapping, and returns the
// first set bit both one-hot (gnt) and encoded (gnt_idx). Reusable by any
// router stage that needs round-robin selection.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] cand;

    // Walk the requests from ptr upward and latch onto the first one found.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/noc_merge_arbiter.sv
// N:1 round-robin merge arbiter for the NoC flit datapath.
// Picks one requesting input per cycle, registers its flit in a single-entry
// output stage and reports which port supplied it. Full throughput: a new flit
// can load on the same edge the held one drains.
// Optional build macro NOC_MERGE_ARB_STATS_EN adds per-port 16-bit saturating
// grant counters readable through stat_sel/stat_count.
module noc_merge_arbiter #(
    parameter int N_PORTS = 4,
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int SRC_W   = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          in_valid,
    input  logic [N_PORTS*FLIT_W-1:0]   in_data,
    output logic [N_PORTS-1:0]          in_ready,
    output logic                        out_valid,
    output logic [FLIT_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready
`ifdef NOC_MERGE_ARB_STATS_EN
    ,
    input  logic [SRC_W-1:0]            stat_sel,
    output logic [15:0]                 stat_count
`endif
);

    logic [SRC_W-1:0]   ptr;
    logic [N_PORTS-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               load_en;
    logic               accept;
    logic [FLIT_W-1:0]  gnt_data;
    logic [SRC_W-1:0]   ptr_next;

    rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (SRC_W)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // The output stage can take a flit when empty or when it drains this edge.
    assign load_en  = !out_valid || out_ready;
    assign accept   = load_en && gnt_valid;
    assign in_ready = (accept && !reset) ? gnt : '0;
    assign ptr_next = (int'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;

    // Mux the winning port's flit out of the packed input bus.
    always_comb begin
        gnt_data = in_data[int'(gnt_idx)*FLIT_W +: FLIT_W];
    end

    // Output register and round-robin pointer; pointer only moves on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOC_MERGE_ARB_STATS_EN
    logic [15:0] grant_cnt [N_PORTS];

    // Per-port grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PORTS; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (accept && gnt[i] && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stat_count = (int'(stat_sel) < N_PORTS) ? grant_cnt[stat_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Self-checking bench for noc_merge_arbiter (N_PORTS=4, FLIT_W=9).
// Table of per-cycle vectors with hand-computed results, plus hand-written
// sequences for reset behaviour and (with NOC_MERGE_ARB_STATS_EN) counters.
module tb_noc_merge_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [35:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [8:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
`ifdef NOC_MERGE_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_count;
`endif

    int nVectors = 0;
    int nMiss    = 0;

    noc_merge_arbiter #(
        .N_PORTS (4),
        .FLIT_W  (9),
        .SRC_W   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef NOC_MERGE_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  valid;
        logic [35:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [8:0]  exp_od;
        logic [1:0]  exp_src;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    localparam logic [35:0] D0 = {9'h013, 9'h012, 9'h011, 9'h010};
    localparam logic [35:0] D1 = {9'h013, 9'h012, 9'h1A5, 9'h010};

    function automatic vec_t mk(input logic [3:0] v, input logic [35:0] d, input logic r,
                                input logic [3:0] er, input logic eov,
                                input logic [8:0] eod, input logic [1:0] es);
        vec_t t;
        t.valid   = v;
        t.data    = d;
        t.ordy    = r;
        t.exp_rdy = er;
        t.exp_ov  = eov;
        t.exp_od  = eod;
        t.exp_src = es;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [35:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        // Round-robin rotation, drains, stall/hold, single requester, wrap.
        vecs[0]  = mk(4'b1111, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[1]  = mk(4'b1111, D0, 1'b1, 4'b0010, 1'b1, 9'h011, 2'd1);
        vecs[2]  = mk(4'b1111, D0, 1'b1, 4'b0100, 1'b1, 9'h012, 2'd2);
        vecs[3]  = mk(4'b1111, D0, 1'b1, 4'b1000, 1'b1, 9'h013, 2'd3);
        vecs[4]  = mk(4'b1111, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[5]  = mk(4'b0000, D0, 1'b1, 4'b0000, 1'b0, 9'h010, 2'd0);
        vecs[6]  = mk(4'b0100, D0, 1'b1, 4'b0100, 1'b1, 9'h012, 2'd2);
        vecs[7]  = mk(4'b1001, D0, 1'b1, 4'b1000, 1'b1, 9'h013, 2'd3);
        vecs[8]  = mk(4'b0001, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[9]  = mk(4'b0011, D0, 1'b1, 4'b0010, 1'b1, 9'h011, 2'd1);
        vecs[10] = mk(4'b0000, D0, 1'b1, 4'b0000, 1'b0, 9'h011, 2'd1);
        vecs[11] = mk(4'b0001, D0, 1'b0, 4'b0001, 1'b1, 9'h010, 2'd0);
        for (int k = 12; k < 17; k++) begin
            vecs[k] = mk(4'b0010, D1, 1'b0, 4'b0000, 1'b1, 9'h010, 2'd0);
        end
        vecs[17] = mk(4'b0010, D1, 1'b1, 4'b0010, 1'b1, 9'h1A5, 2'd1);
        vecs[18] = mk(4'b0000, D1, 1'b0, 4'b0000, 1'b1, 9'h1A5, 2'd1);
        vecs[19] = mk(4'b0000, D1, 1'b1, 4'b0000, 1'b0, 9'h1A5, 2'd1);
        vecs[20] = mk(4'b0001, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[21] = mk(4'b0001, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[22] = mk(4'b1000, D0, 1'b1, 4'b1000, 1'b1, 9'h013, 2'd3);
        vecs[23] = mk(4'b1001, D0, 1'b1, 4'b0001, 1'b1, 9'h010, 2'd0);
        vecs[24] = mk(4'b0000, D0, 1'b1, 4'b0000, 1'b0, 9'h010, 2'd0);

        // Reset asserted with requests present: nothing may be accepted.
        reset     = 1'b1;
        in_valid  = 4'b1111;
        in_data   = D0;
        out_ready = 1'b1;
`ifdef NOC_MERGE_ARB_STATS_EN
        stat_sel  = 2'd0;
`endif
        #3;
        checkOutput("rst.in_ready", {12'b0, in_ready}, 16'h0);
        checkOutput("rst.out_valid", {15'b0, out_valid}, 16'h0);

        @(negedge clk);
        reset    = 1'b0;
        in_valid = 4'b0000;

        // Idle after reset release.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle%0d.out_valid", c), {15'b0, out_valid}, 16'h0);
            checkOutput($sformatf("idle%0d.in_ready", c), {12'b0, in_ready}, 16'h0);
            checkOutput($sformatf("idle%0d.out_src", c), {14'b0, out_src}, 16'h0);
            checkOutput($sformatf("idle%0d.out_data", c), {7'b0, out_data}, 16'h0);
        end

        // Table-driven vectors.
        for (int k = 0; k < NV; k++) begin
            applyStimulus(vecs[k].valid, vecs[k].data, vecs[k].ordy);
            #1;
            checkOutput($sformatf("v%0d.in_ready", k), {12'b0, in_ready}, {12'b0, vecs[k].exp_rdy});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d.out_valid", k), {15'b0, out_valid}, {15'b0, vecs[k].exp_ov});
            checkOutput($sformatf("v%0d.out_data", k), {7'b0, out_data}, {7'b0, vecs[k].exp_od});
            checkOutput($sformatf("v%0d.out_src", k), {14'b0, out_src}, {14'b0, vecs[k].exp_src});
        end

        // Asynchronous reset mid-cycle while a flit is held (ptr is 1 here).
        applyStimulus(4'b0100, D0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("arst.pre_out_valid", {15'b0, out_valid}, 16'h1);
        checkOutput("arst.pre_out_data", {7'b0, out_data}, 16'h012);
        #2;
        in_valid = 4'b0000;
        reset    = 1'b1;
        #1;
        checkOutput("arst.out_valid", {15'b0, out_valid}, 16'h0);
        checkOutput("arst.out_data", {7'b0, out_data}, 16'h0);
        checkOutput("arst.out_src", {14'b0, out_src}, 16'h0);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 4'b1100;
        out_ready = 1'b1;
        #1;
        checkOutput("arst.ptr0_in_ready", {12'b0, in_ready}, 16'h0004);
        @(posedge clk);
        #1;
        checkOutput("arst.ptr0_out_src", {14'b0, out_src}, 16'h2);
        checkOutput("arst.ptr0_out_data", {7'b0, out_data}, 16'h012);
        applyStimulus(4'b0000, D0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("arst.drain_out_valid", {15'b0, out_valid}, 16'h0);

`ifdef NOC_MERGE_ARB_STATS_EN
        // Grant counters: port0 x3, port1 x5, port2 x70000 (saturates), port3 none.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) applyStimulus(4'b0001, D0, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(4'b0010, D0, 1'b1);
        for (int c = 0; c < 70000; c++) applyStimulus(4'b0100, D0, 1'b1);
        applyStimulus(4'b0000, D0, 1'b1);
        @(negedge clk);
        stat_sel = 2'd0;
        #1;
        checkOutput("stat.port0", stat_count, 16'd3);
        stat_sel = 2'd1;
        #1;
        checkOutput("stat.port1", stat_count, 16'd5);
        stat_sel = 2'd2;
        #1;
        checkOutput("stat.port2", stat_count, 16'hFFFF);
        stat_sel = 2'd3;
        #1;
        checkOutput("stat.port3", stat_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
